// File: rtl/hazard_ctrl.sv
// Hazard controller at the ID/EX boundary of the 5-stage OTTER pipeline: load-use bubbles,
// redirect flushes (including IMEM latency) and memory-wait freezes. HAZARD_PERF_EN adds perf counters.
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [4:0]       IF_ID_RS1,
   input  logic [4:0]       IF_ID_RS2,
   input  logic             IF_ID_useRS1,
   input  logic             IF_ID_useRS2,
   input  logic [4:0]       ID_EX_RD,
   input  logic             ID_EX_memRead,
   input  logic             EX_branchTaken,
   input  logic             MEM_dmemBusy,
   output logic             PC_write,
   output logic             IF_ID_write,
   output logic             ID_EX_write,
   output logic             EX_MEM_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic [CNT_W-1:0] loadStallCnt,
   output logic [CNT_W-1:0] flushCnt,
   output logic [CNT_W-1:0] memWaitCnt
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

   state_t     r_state, w_state_nxt;
   logic [1:0] r_flushLeft, w_flushLeft_nxt;

   logic w_hazard;
   logic w_memWait, w_redirect, w_flushState, w_loadUse;

   assign w_hazard = ID_EX_memRead && (ID_EX_RD != 5'd0) &&
                     ((IF_ID_useRS1 && (IF_ID_RS1 == ID_EX_RD)) ||
                      (IF_ID_useRS2 && (IF_ID_RS2 == ID_EX_RD)));

   // Priority chain: memory wait > redirect > flush state > load-use.
   assign w_memWait    = MEM_dmemBusy;
   assign w_redirect   = !MEM_dmemBusy && EX_branchTaken;
   assign w_flushState = !MEM_dmemBusy && !EX_branchTaken && (r_state == FLUSH);
   assign w_loadUse    = !MEM_dmemBusy && !EX_branchTaken && (r_state == RUN) && w_hazard;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= RUN;
         r_flushLeft <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_flushLeft <= w_flushLeft_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_flushLeft_nxt = r_flushLeft;
      PC_write        = 1'b1;
      IF_ID_write     = 1'b1;
      ID_EX_write     = 1'b1;
      EX_MEM_write    = 1'b1;
      IF_ID_flush     = 1'b0;
      ID_EX_flush     = 1'b0;
      if (!RST_N) begin
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_write  = 1'b0;
         EX_MEM_write = 1'b0;
         IF_ID_flush  = 1'b1;
         ID_EX_flush  = 1'b1;
      end else if (w_memWait) begin
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_write  = 1'b0;
         EX_MEM_write = 1'b0;
      end else if (w_redirect) begin
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
         if (FLUSH_CYCLES > 0) begin
            w_state_nxt     = FLUSH;
            w_flushLeft_nxt = FLUSH_LOAD;
         end else begin
            w_state_nxt     = RUN;
            w_flushLeft_nxt = 2'd0;
         end
      end else if (w_flushState) begin
         IF_ID_flush     = 1'b1;
         w_flushLeft_nxt = r_flushLeft - 2'd1;
         if (r_flushLeft <= 2'd1) begin
            w_state_nxt     = RUN;
            w_flushLeft_nxt = 2'd0;
         end
      end else if (w_loadUse) begin
         PC_write    = 1'b0;
         IF_ID_write = 1'b0;
         ID_EX_flush = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_loadStallCnt, r_flushCnt, r_memWaitCnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_loadStallCnt <= '0;
         r_flushCnt     <= '0;
         r_memWaitCnt   <= '0;
      end else begin
         if (w_loadUse && (r_loadStallCnt != '1))
            r_loadStallCnt <= r_loadStallCnt + CNT_W'(1);
         if ((w_redirect || w_flushState) && (r_flushCnt != '1))
            r_flushCnt <= r_flushCnt + CNT_W'(1);
         if (w_memWait && (r_memWaitCnt != '1))
            r_memWaitCnt <= r_memWaitCnt + CNT_W'(1);
      end
   end

   assign loadStallCnt = r_loadStallCnt;
   assign flushCnt     = r_flushCnt;
   assign memWaitCnt   = r_memWaitCnt;
`else
   assign loadStallCnt = '0;
   assign flushCnt     = '0;
   assign memWaitCnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with FLUSH_CYCLES=1/CNT_W=32 and one with
// FLUSH_CYCLES=0/CNT_W=2 sharing stimulus (the narrow counters exercise saturation).
module tb_hazard_ctrl;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [4:0] IF_ID_RS1, IF_ID_RS2, ID_EX_RD;
   logic       IF_ID_useRS1, IF_ID_useRS2, ID_EX_memRead, EX_branchTaken, MEM_dmemBusy;

   logic        pc1, ifw1, idw1, exw1, iff1, idf1;
   logic        pc0, ifw0, idw0, exw0, iff0, idf0;
   logic [31:0] ls1, fl1, mw1;
   logic [1:0]  ls0, fl0, mw0;

   int checks = 0;
   int errors = 0;

   // Output vector order: {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, IF_ID_flush, ID_EX_flush}
   localparam logic [5:0] V_RST  = 6'b000011;
   localparam logic [5:0] V_NORM = 6'b111100;
   localparam logic [5:0] V_LU   = 6'b001101;
   localparam logic [5:0] V_BUSY = 6'b000000;
   localparam logic [5:0] V_RED  = 6'b111111;
   localparam logic [5:0] V_FLSH = 6'b111110;

`ifdef HAZARD_PERF_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   always #5 CLK = ~CLK;

   hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) u_dut1 (
      .CLK(CLK), .RST_N(RST_N),
      .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2),
      .IF_ID_useRS1(IF_ID_useRS1), .IF_ID_useRS2(IF_ID_useRS2),
      .ID_EX_RD(ID_EX_RD), .ID_EX_memRead(ID_EX_memRead),
      .EX_branchTaken(EX_branchTaken), .MEM_dmemBusy(MEM_dmemBusy),
      .PC_write(pc1), .IF_ID_write(ifw1), .ID_EX_write(idw1), .EX_MEM_write(exw1),
      .IF_ID_flush(iff1), .ID_EX_flush(idf1),
      .loadStallCnt(ls1), .flushCnt(fl1), .memWaitCnt(mw1)
   );

   hazard_ctrl #(.FLUSH_CYCLES(0), .CNT_W(2)) u_dut0 (
      .CLK(CLK), .RST_N(RST_N),
      .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2),
      .IF_ID_useRS1(IF_ID_useRS1), .IF_ID_useRS2(IF_ID_useRS2),
      .ID_EX_RD(ID_EX_RD), .ID_EX_memRead(ID_EX_memRead),
      .EX_branchTaken(EX_branchTaken), .MEM_dmemBusy(MEM_dmemBusy),
      .PC_write(pc0), .IF_ID_write(ifw0), .ID_EX_write(idw0), .EX_MEM_write(exw0),
      .IF_ID_flush(iff0), .ID_EX_flush(idf0),
      .loadStallCnt(ls0), .flushCnt(fl0), .memWaitCnt(mw0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sample both instances at the falling edge, then advance to just after the next rising edge.
   task automatic step(input string tag, input logic [5:0] e1, input logic [5:0] e0);
      @(negedge CLK);
      chk({tag, "/fc1"}, {26'd0, pc1, ifw1, idw1, exw1, iff1, idf1}, {26'd0, e1});
      chk({tag, "/fc0"}, {26'd0, pc0, ifw0, idw0, exw0, iff0, idf0}, {26'd0, e0});
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      IF_ID_RS1 = 5'd0; IF_ID_RS2 = 5'd0; ID_EX_RD = 5'd0;
      IF_ID_useRS1 = 1'b0; IF_ID_useRS2 = 1'b0; ID_EX_memRead = 1'b0;
      EX_branchTaken = 1'b0; MEM_dmemBusy = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST_N = 1'b0;
      idle_inputs();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_outs1", {26'd0, pc1, ifw1, idw1, exw1, iff1, idf1}, {26'd0, V_RST});
      chk("rst_outs0", {26'd0, pc0, ifw0, idw0, exw0, iff0, idf0}, {26'd0, V_RST});
      chk("rst_cnt1", ls1 | fl1 | mw1, 32'd0);
      @(posedge CLK);
      #1 RST_N = 1'b1;
      step("idle", V_NORM, V_NORM);

      // Load-use via rs2, then bubble clears memRead
      ID_EX_memRead = 1'b1; ID_EX_RD = 5'd5; IF_ID_RS2 = 5'd5; IF_ID_useRS2 = 1'b1;
      step("lu_rs2", V_LU, V_LU);
      ID_EX_memRead = 1'b0;
      step("lu_rs2_after", V_NORM, V_NORM);

      // Load-use via rs1
      idle_inputs();
      ID_EX_memRead = 1'b1; ID_EX_RD = 5'd7; IF_ID_RS1 = 5'd7; IF_ID_useRS1 = 1'b1;
      step("lu_rs1", V_LU, V_LU);
      // Matching address but operand unused
      IF_ID_useRS1 = 1'b0;
      step("lu_unused", V_NORM, V_NORM);
      // rd=x0 never stalls
      ID_EX_RD = 5'd0; IF_ID_RS1 = 5'd0; IF_ID_RS2 = 5'd0; IF_ID_useRS1 = 1'b1; IF_ID_useRS2 = 1'b1;
      step("lu_x0", V_NORM, V_NORM);
      // Load to a different register
      ID_EX_RD = 5'd9; IF_ID_RS1 = 5'd8; IF_ID_RS2 = 5'd10;
      step("lu_nomatch", V_NORM, V_NORM);
      idle_inputs();

      // Redirect pulse
      EX_branchTaken = 1'b1;
      step("redir_c0", V_RED, V_RED);
      EX_branchTaken = 1'b0;
      step("redir_c1", V_FLSH, V_NORM);
      step("redir_c2", V_NORM, V_NORM);

      // Memory wait with load-use pending
      ID_EX_memRead = 1'b1; ID_EX_RD = 5'd5; IF_ID_RS2 = 5'd5; IF_ID_useRS2 = 1'b1;
      MEM_dmemBusy = 1'b1;
      for (int i = 0; i < 4; i++) step("memwait", V_BUSY, V_BUSY);
      MEM_dmemBusy = 1'b0;
      step("memwait_lu", V_LU, V_LU);
      ID_EX_memRead = 1'b0;
      step("memwait_after", V_NORM, V_NORM);
      idle_inputs();

      // Busy arriving during FLUSH
      EX_branchTaken = 1'b1;
      step("bf_redir", V_RED, V_RED);
      EX_branchTaken = 1'b0; MEM_dmemBusy = 1'b1;
      step("bf_busy0", V_BUSY, V_BUSY);
      step("bf_busy1", V_BUSY, V_BUSY);
      MEM_dmemBusy = 1'b0;
      step("bf_resume", V_FLSH, V_NORM);
      step("bf_done", V_NORM, V_NORM);

      // Redirect while in FLUSH reloads; load-use suppressed in FLUSH
      EX_branchTaken = 1'b1;
      step("rl_redir0", V_RED, V_RED);
      step("rl_redir1", V_RED, V_RED);
      EX_branchTaken = 1'b0;
      ID_EX_memRead = 1'b1; ID_EX_RD = 5'd3; IF_ID_RS1 = 5'd3; IF_ID_useRS1 = 1'b1;
      step("rl_flush_supp", V_FLSH, V_LU);
      ID_EX_memRead = 1'b0;
      step("rl_done", V_NORM, V_NORM);
      idle_inputs();

      // Counters: fc1 sees 3 load-use, 7 flush, 6 wait cycles; fc0 (2-bit) saturates at 3
      @(negedge CLK);
      chk("cnt_ls1", ls1, PERF ? 32'd3 : 32'd0);
      chk("cnt_fl1", fl1, PERF ? 32'd7 : 32'd0);
      chk("cnt_mw1", mw1, PERF ? 32'd6 : 32'd0);
      chk("cnt_ls0_sat", {30'd0, ls0}, PERF ? 32'd3 : 32'd0);
      chk("cnt_fl0_sat", {30'd0, fl0}, PERF ? 32'd3 : 32'd0);
      chk("cnt_mw0_sat", {30'd0, mw0}, PERF ? 32'd3 : 32'd0);
      @(posedge CLK);
      #1;

      // Asynchronous reset while fc1 is in FLUSH
      EX_branchTaken = 1'b1;
      step("ar_redir", V_RED, V_RED);
      EX_branchTaken = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      chk("ar_outs1", {26'd0, pc1, ifw1, idw1, exw1, iff1, idf1}, {26'd0, V_RST});
      chk("ar_outs0", {26'd0, pc0, ifw0, idw0, exw0, iff0, idf0}, {26'd0, V_RST});
      chk("ar_cnt1", ls1 | fl1 | mw1, 32'd0);
      chk("ar_cnt0", {30'd0, ls0 | fl0 | mw0}, 32'd0);
      @(posedge CLK);
      #1 RST_N = 1'b1;
      step("ar_release", V_NORM, V_NORM);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage OTTER core.
- Sits beside the ID/EX boundary, directly upstream of the EX-stage operand-forwarding logic. It guarantees that when an instruction reaches EX, any hazard forwarding cannot fix has already been resolved.
- Handles three hazard classes:
  - load-use: inserts one bubble;
  - taken branch/jump: flushes wrong-path instructions, including the extra wrong-path fetch caused by synchronous IMEM;
  - data-memory wait: freezes the whole pipeline.

Parameters:
- FLUSH_CYCLES, default 1: extra cycles IF/ID is flushed after a redirect (IMEM read latency). Range 0..3.
- CNT_W, default 32: width of the performance counters (optional feature only).

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous reset, active-low
- IF_ID_RS1  in  5  rs1 address of the instruction in ID
- IF_ID_RS2  in  5  rs2 address of the instruction in ID
- IF_ID_useRS1  in  1  ID instruction reads rs1
- IF_ID_useRS2  in  1  ID instruction reads rs2
- ID_EX_RD  in  5  rd of the instruction in EX
- ID_EX_memRead  in  1  EX instruction is a load
- EX_branchTaken  in  1  EX resolved a taken branch/jal/jalr (PC redirect this cycle)
- MEM_dmemBusy  in  1  data memory not ready; MEM stage must hold
- PC_write  out  1  PC register enable
- IF_ID_write  out  1  IF/ID register enable
- ID_EX_write  out  1  ID/EX register enable
- EX_MEM_write  out  1  EX/MEM register enable
- IF_ID_flush  out  1  load a NOP into IF/ID
- ID_EX_flush  out  1  load a NOP into ID/EX (bubble)
- loadStallCnt  out  CNT_W  load-use stall cycles
- flushCnt  out  CNT_W  flush cycles
- memWaitCnt  out  CNT_W  memory-wait cycles

Behaviour:

State and reset:
- States: RUN, FLUSH. Counter flushLeft, 2 bits.
- While RST_N=0 (asynchronous): state=RUN, flushLeft=0, all counters 0.
- Outputs while RST_N=0: PC_write=IF_ID_write=ID_EX_write=EX_MEM_write=0; IF_ID_flush=ID_EX_flush=1.
- After release, outputs follow the decode below starting in the same cycle.

Output decode:
- Outputs are combinational from state plus inputs. Only state and counters are registered.
- Default (no hazard): all *_write=1, all flushes=0.
- Priority, highest first: memory wait > redirect > flush state > load-use.

1. Memory wait (MEM_dmemBusy=1, any state):
   - All *_write=0, flushes=0.
   - State and flushLeft hold. A pending redirect or load-use is re-evaluated once busy drops.
   - Because EX is frozen, the inputs stay stable during the wait.
2. Redirect (EX_branchTaken=1, busy=0, any state):
   - IF_ID_flush=1, ID_EX_flush=1, PC_write=1.
   - Next state: FLUSH with flushLeft=FLUSH_CYCLES if FLUSH_CYCLES>0; otherwise RUN.
   - A redirect while already in FLUSH reloads flushLeft.
3. FLUSH (busy=0, no redirect):
   - IF_ID_flush=1, ID_EX_flush=0, all writes=1.
   - flushLeft decrements each cycle; at flushLeft==1 the next state is RUN.
   - Load-use detection is suppressed, since ID holds a NOP.
4. Load-use (RUN only):
   - Condition: ID_EX_memRead && ID_EX_RD!=0 && ((IF_ID_useRS1 && IF_ID_RS1==ID_EX_RD) || (IF_ID_useRS2 && IF_ID_RS2==ID_EX_RD)).
   - Response: PC_write=0, IF_ID_write=0, ID_EX_flush=1, EX_MEM_write=1, ID_EX_write=1.
   - Lasts exactly one cycle: the bubble clears memRead. No state change.
   - rd=x0 never stalls.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: each counter increments by 1 per cycle in which its condition is the active (highest-priority) one:
  - loadStallCnt: load-use cycle;
  - flushCnt: redirect cycle or FLUSH-state cycle;
  - memWaitCnt: busy cycle.
  - Counters saturate at 2^CNT_W-1 and reset asynchronously to 0.
- Undefined: counter ports are present, tied to 0, and no counter flops are inferred.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles → writes all 0, flushes all 1. Release → all writes=1, flushes=0 with idle inputs.
- Load-use: ID_EX_memRead=1, ID_EX_RD=5, IF_ID_RS2=5, useRS2=1 → exactly 1 cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1. Repeat with RD=0 → no stall.
- Redirect, FLUSH_CYCLES=1: EX_branchTaken pulse → cycle 0: both flushes=1. Cycle 1: IF_ID_flush=1 only. Cycle 2: normal. Repeat with FLUSH_CYCLES=0 → only cycle 0 flushes.
- Memory wait: MEM_dmemBusy=1 for 4 cycles with load-use inputs present → 4 cycles of all writes=0. Then exactly 1 load-use stall cycle.
- Busy during FLUSH: redirect, then busy=1 for 2 cycles → flush resumes after busy drops, flushLeft unchanged, total IF_ID_flush cycles = FLUSH_CYCLES+1.
- HAZARD_PERF_EN: run the four scenarios above, then check loadStallCnt=1, flushCnt=2, memWaitCnt=4 for the matching scenarios. Force counters near max → they saturate.
